// File: rtl/attn_pkg.sv
// Shared types and helpers for the attention datapath: FSM state type,
// flat-index arithmetic for row-major operand buses, and a signed clamp.
package attn_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_MAC,
    ST_STORE,
    ST_DONE
  } proj_state_t;

  localparam int unsigned DEF_DATA_WIDTH = 16;
  localparam int unsigned DEF_FRAC_BITS  = 8;
  localparam int unsigned DEF_SEQ_LEN    = 8;
  localparam int unsigned DEF_EMB_DIM    = 8;

  // Row-major flat index: element [row][col] of a matrix with ncols columns.
  function automatic int unsigned flat_idx(input int unsigned row,
                                           input int unsigned col,
                                           input int unsigned ncols);
    return row * ncols + col;
  endfunction

  // Clamp a signed value to the range of a w-bit two's-complement number (w <= 64).
  function automatic logic signed [63:0] sat_signed(input logic signed [63:0] v,
                                                    input int unsigned        w);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

endpackage

// File: rtl/fxp_mac.sv
// Signed multiply-accumulate: acc += a*b when enabled, synchronous clear
// takes priority over enable.
module fxp_mac #(
  parameter int DATA_WIDTH = 16,
  parameter int ACC_WIDTH  = 40
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         clr_i,
  input  logic                         en_i,
  input  logic signed [DATA_WIDTH-1:0] a_i,
  input  logic signed [DATA_WIDTH-1:0] b_i,
  output logic signed [ACC_WIDTH-1:0]  acc_o
);

  logic signed [2*DATA_WIDTH-1:0] prod;
  logic signed [ACC_WIDTH-1:0]    acc_q;

  assign prod  = (2*DATA_WIDTH)'(a_i) * (2*DATA_WIDTH)'(b_i);
  assign acc_o = acc_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
    end else if (clr_i) begin
      acc_q <= '0;
    end else if (en_i) begin
      acc_q <= acc_q + ACC_WIDTH'(prod);
    end
  end

endmodule

// File: rtl/attn_out_proj_residual.sv
// Attention output projection with residual add: out = sat(attn*WO^T>>>F + bO + x),
// one MAC per cycle, start/done handshake. dbg_state exposes the FSM.
module attn_out_proj_residual
  import attn_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int FRAC_BITS  = 8,
  parameter int SEQ_LEN    = 8,
  parameter int EMB_DIM    = 8,
  parameter int ACC_WIDTH  = 40
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic                                  start,
  input  logic [DATA_WIDTH*SEQ_LEN*EMB_DIM-1:0] attn_in,
  input  logic [DATA_WIDTH*SEQ_LEN*EMB_DIM-1:0] x_in,
  input  logic [DATA_WIDTH*EMB_DIM*EMB_DIM-1:0] WO_in,
  input  logic [DATA_WIDTH*EMB_DIM-1:0]         bO_in,
  output logic                                  busy,
  output logic                                  done,
  output logic                                  out_valid,
  output logic [DATA_WIDTH*SEQ_LEN*EMB_DIM-1:0] proj_out,
  output proj_state_t                           dbg_state
);

  localparam int NE = SEQ_LEN * EMB_DIM;
  localparam int NW = EMB_DIM * EMB_DIM;
  localparam int IW = (SEQ_LEN > 1) ? $clog2(SEQ_LEN) : 1;
  localparam int KW = (EMB_DIM > 1) ? $clog2(EMB_DIM) : 1;
  localparam int AW = (NE > 1) ? $clog2(NE) : 1;
  localparam int WW = (NW > 1) ? $clog2(NW) : 1;

  proj_state_t state_q, state_d;

  logic signed [DATA_WIDTH-1:0] attn_q [NE];
  logic signed [DATA_WIDTH-1:0] x_q    [NE];
  logic signed [DATA_WIDTH-1:0] wo_q   [NW];
  logic signed [DATA_WIDTH-1:0] bo_q   [EMB_DIM];
  logic signed [DATA_WIDTH-1:0] out_q  [NE];

  logic [IW-1:0] i_q;
  logic [KW-1:0] d_q, k_q;
  logic          out_valid_q;

  logic [AW-1:0] a_idx, o_idx;
  logic [WW-1:0] w_idx;
  logic          last_k, last_d, last_elem;
  logic          mac_clr, mac_en;

  logic signed [ACC_WIDTH-1:0] acc;
  logic signed [ACC_WIDTH-1:0] x_ext, b_ext, r_sum;
  logic signed [63:0]          r_sat;

  // Handshake: start is a level sampled only in IDLE; busy spans LOAD..DONE,
  // done is a one-cycle pulse in DONE, out_valid holds until the next accepted start.
  assign busy      = (state_q != ST_IDLE);
  assign done      = (state_q == ST_DONE);
  assign out_valid = out_valid_q;
  assign dbg_state = state_q;
  assign mac_clr   = (state_q == ST_LOAD) || (state_q == ST_STORE);
  assign mac_en    = (state_q == ST_MAC);

  always_comb begin
    a_idx     = AW'(flat_idx(32'(i_q), 32'(k_q), EMB_DIM));
    w_idx     = WW'(flat_idx(32'(d_q), 32'(k_q), EMB_DIM));
    o_idx     = AW'(flat_idx(32'(i_q), 32'(d_q), EMB_DIM));
    last_k    = (k_q == KW'(EMB_DIM - 1));
    last_d    = (d_q == KW'(EMB_DIM - 1));
    last_elem = last_d && (i_q == IW'(SEQ_LEN - 1));
  end

  fxp_mac #(
    .DATA_WIDTH(DATA_WIDTH),
    .ACC_WIDTH (ACC_WIDTH)
  ) u_mac (
    .clk  (clk),
    .rst_n(rst_n),
    .clr_i(mac_clr),
    .en_i (mac_en),
    .a_i  (attn_q[a_idx]),
    .b_i  (wo_q[w_idx]),
    .acc_o(acc)
  );

  // Arithmetic shift truncates toward -inf; residual and bias join at full width.
  always_comb begin
    x_ext = ACC_WIDTH'(x_q[o_idx]);
    b_ext = ACC_WIDTH'(bo_q[d_q]);
    r_sum = (acc >>> FRAC_BITS) + x_ext + b_ext;
    r_sat = sat_signed(64'(r_sum), DATA_WIDTH);
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (start) state_d = ST_LOAD;
      ST_LOAD:  state_d = ST_MAC;
      ST_MAC:   if (last_k) state_d = ST_STORE;
      ST_STORE: state_d = last_elem ? ST_DONE : ST_MAC;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int n = 0; n < NE; n++) begin
        attn_q[n] <= '0;
        x_q[n]    <= '0;
        out_q[n]  <= '0;
      end
      for (int n = 0; n < NW; n++) wo_q[n] <= '0;
      for (int n = 0; n < EMB_DIM; n++) bo_q[n] <= '0;
      i_q         <= '0;
      d_q         <= '0;
      k_q         <= '0;
      out_valid_q <= 1'b0;
    end else begin
      unique case (state_q)
        ST_LOAD: begin
          for (int n = 0; n < NE; n++) begin
            attn_q[n] <= attn_in[n*DATA_WIDTH +: DATA_WIDTH];
            x_q[n]    <= x_in[n*DATA_WIDTH +: DATA_WIDTH];
          end
          for (int n = 0; n < NW; n++) wo_q[n] <= WO_in[n*DATA_WIDTH +: DATA_WIDTH];
          for (int n = 0; n < EMB_DIM; n++) bo_q[n] <= bO_in[n*DATA_WIDTH +: DATA_WIDTH];
          i_q <= '0;
          d_q <= '0;
          k_q <= '0;
        end
        ST_MAC: k_q <= k_q + KW'(1);
        ST_STORE: begin
          out_q[o_idx] <= r_sat[DATA_WIDTH-1:0];
          k_q          <= '0;
          if (last_d) begin
            d_q <= '0;
            i_q <= i_q + IW'(1);
          end else begin
            d_q <= d_q + KW'(1);
          end
        end
        default: ;
      endcase

      if ((state_q == ST_IDLE) && start) begin
        out_valid_q <= 1'b0;
      end else if (state_d == ST_DONE) begin
        out_valid_q <= 1'b1;
      end
    end
  end

  always_comb begin
    proj_out = '0;
    for (int n = 0; n < NE; n++) begin
      proj_out[n*DATA_WIDTH +: DATA_WIDTH] = out_q[n];
    end
  end

endmodule

// File: tb/tb_attn_out_proj_residual.sv
// Directed bench for attn_out_proj_residual at SEQ_LEN=2, EMB_DIM=2, Q8.8:
// vector table plus hand sequences for handshake, input stability and reset.
module tb_attn_out_proj_residual;
  import attn_pkg::*;

  localparam int DW  = 16;
  localparam int SL  = 2;
  localparam int ED  = 2;
  localparam int LAT = 1 + SL * ED * (ED + 1);  // edges from start edge to done cycle
  localparam int NV  = 6;

  typedef struct {
    logic [63:0] attn;
    logic [63:0] x;
    logic [63:0] wo;
    logic [31:0] bo;
    logic [63:0] exp;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [63:0] attn_in = '0;
  logic [63:0] x_in = '0;
  logic [63:0] wo_in = '0;
  logic [31:0] bo_in = '0;
  logic        busy, done, out_valid;
  logic [63:0] proj_out;
  proj_state_t dbg_state;

  int   errors = 0;
  int   checks = 0;
  vec_t vecs [NV];

  attn_out_proj_residual #(
    .DATA_WIDTH(DW),
    .FRAC_BITS (8),
    .SEQ_LEN   (SL),
    .EMB_DIM   (ED),
    .ACC_WIDTH (40)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .attn_in  (attn_in),
    .x_in     (x_in),
    .WO_in    (wo_in),
    .bO_in    (bo_in),
    .busy     (busy),
    .done     (done),
    .out_valid(out_valid),
    .proj_out (proj_out),
    .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  function automatic logic [63:0] p4(input logic [15:0] e0, input logic [15:0] e1,
                                     input logic [15:0] e2, input logic [15:0] e3);
    return {e3, e2, e1, e0};
  endfunction

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic apply(input vec_t v);
    attn_in = v.attn;
    x_in    = v.x;
    wo_in   = v.wo;
    bo_in   = v.bo;
  endtask

  // Pulse start, then count edges until done; optional mid-run start pulse and input scramble.
  task automatic run_once(input int pulse_at, input int chg_at, output int n, output bit busy_ok);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    busy_ok = busy && !out_valid;
    while (!done && n < 100) begin
      @(negedge clk);
      n++;
      start = (n == pulse_at);
      if (n == chg_at) begin
        attn_in = {$urandom, $urandom};
        x_in    = {$urandom, $urandom};
        wo_in   = {$urandom, $urandom};
        bo_in   = $urandom;
      end
      if (!busy) busy_ok = 1'b0;
    end
    start = 1'b0;
  endtask

  task automatic after_done(input string tag, input logic [63:0] exp);
    @(negedge clk);
    check({tag, "_done_drop"}, 64'(done), 64'd0);
    check({tag, "_busy_drop"}, 64'(busy), 64'd0);
    check({tag, "_valid_hold"}, 64'(out_valid), 64'd1);
    check({tag, "_out_hold"}, proj_out, exp);
  endtask

  initial begin
    int  n, n2, extra;
    bit  ok;
    // identity projection
    vecs[0] = '{attn: p4(16'h0100, 16'h0200, 16'hFF00, 16'h0080), x: 64'h0,
                wo: p4(16'h0100, 16'h0000, 16'h0000, 16'h0100), bo: 32'h0,
                exp: p4(16'h0100, 16'h0200, 16'hFF00, 16'h0080)};
    vecs[1] = '{attn: {4{16'h7FFF}}, x: 64'h0, wo: {4{16'h7FFF}}, bo: 32'h0,
                exp: {4{16'h7FFF}}};
    vecs[2] = '{attn: {4{16'h7FFF}}, x: 64'h0, wo: {4{16'h8000}}, bo: 32'h0,
                exp: {4{16'h8000}}};
    // -1 * 0.5 = -128 raw, >>>8 gives -1, not 0
    vecs[3] = '{attn: {4{16'hFFFF}}, x: 64'h0,
                wo: p4(16'h0080, 16'h0000, 16'h0000, 16'h0080), bo: 32'h0,
                exp: {4{16'hFFFF}}};
    // attn=[1,1;2,-1], WO=[1,.5;.25,-1], bO=[16,-16]/256, x=[1,0;0,2]/256
    vecs[4] = '{attn: p4(16'h0100, 16'h0100, 16'h0200, 16'hFF00),
                x: p4(16'h0001, 16'h0000, 16'h0000, 16'h0002),
                wo: p4(16'h0100, 16'h0080, 16'h0040, 16'hFF00),
                bo: {16'hFFF0, 16'h0010},
                exp: p4(16'h0191, 16'hFF30, 16'h0190, 16'h0172)};
    vecs[5] = '{attn: p4(16'h0100, 16'h0200, 16'hFF00, 16'h0080), x: {4{16'h0100}},
                wo: 64'h0, bo: {16'h0080, 16'h0080}, exp: {4{16'h0180}}};

    // clock/reset
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_valid", 64'(out_valid), 64'd0);
    check("rst_out", proj_out, 64'h0);
    check("rst_state", 64'(dbg_state), 64'(ST_IDLE));
    rst_n = 1'b1;

    for (int t = 0; t < NV; t++) begin
      apply(vecs[t]);
      run_once(-1, -1, n, ok);
      check($sformatf("v%0d_latency", t), 64'(n), 64'(LAT));
      check($sformatf("v%0d_busy", t), 64'(ok), 64'd1);
      check($sformatf("v%0d_result", t), proj_out, vecs[t].exp);
      check($sformatf("v%0d_valid_at_done", t), 64'(out_valid), 64'd1);
      after_done($sformatf("v%0d", t), vecs[t].exp);
    end

    // out_valid and result hold through idle cycles
    ok = 1'b1;
    repeat (20) begin
      @(negedge clk);
      if (!out_valid || busy || proj_out !== vecs[NV-1].exp) ok = 1'b0;
    end
    check("idle_hold", 64'(ok), 64'd1);

    // start pulsed mid-run is ignored, nothing queued
    apply(vecs[0]);
    run_once(5, -1, n, ok);
    check("midstart_latency", 64'(n), 64'(LAT));
    check("midstart_result", proj_out, vecs[0].exp);
    extra = 0;
    repeat (20) begin
      @(negedge clk);
      if (done || busy) extra++;
    end
    check("midstart_no_rerun", 64'(extra), 64'd0);

    // inputs scrambled after LOAD must not affect the result
    apply(vecs[4]);
    run_once(-1, 2, n, ok);
    check("stable_latency", 64'(n), 64'(LAT));
    check("stable_result", proj_out, vecs[4].exp);

    // start held high: back-to-back runs with one IDLE cycle between
    apply(vecs[0]);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    n = 0;
    while (!done && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("hold_latency1", 64'(n), 64'(LAT));
    @(negedge clk);
    check("hold_idle_state", 64'(dbg_state), 64'(ST_IDLE));
    check("hold_idle_valid", 64'(out_valid), 64'd1);
    @(negedge clk);
    check("hold_load_busy", 64'(busy), 64'd1);
    check("hold_load_valid_clr", 64'(out_valid), 64'd0);
    n2 = 0;
    while (!done && n2 < 100) begin
      @(negedge clk);
      n2++;
    end
    start = 1'b0;
    check("hold_latency2", 64'(n2), 64'(LAT));
    check("hold_result", proj_out, vecs[0].exp);
    repeat (3) @(negedge clk);

    // asynchronous reset mid-MAC aborts and clears everything
    apply(vecs[0]);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (6) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("arst_out", proj_out, 64'h0);
    check("arst_valid", 64'(out_valid), 64'd0);
    check("arst_busy", 64'(busy), 64'd0);
    check("arst_state", 64'(dbg_state), 64'(ST_IDLE));
    @(negedge clk);
    rst_n = 1'b1;
    run_once(-1, -1, n, ok);
    check("arst_rerun_latency", 64'(n), 64'(LAT));
    check("arst_rerun_result", proj_out, vecs[0].exp);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
